// File: rtl/bit_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// bit_serial_adder_pkg
// Shared definitions for the bit-serial adder slice.
//   state_t        : FSM encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand / sum width in bits
// ---------------------------------------------------------------------------
package bit_serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bit_serial_adder_if.sv
// ---------------------------------------------------------------------------
// bit_serial_adder_if
// Request / result bundle between a client and the bit-serial adder.
//   start       : request to begin an addition (client -> adder)
//   a, b, cin   : operands and carry-in, captured on an accepted start
//   busy        : bits are being processed (adder -> client)
//   done        : one-cycle pulse, sum/cout valid
//   sum, cout   : WIDTH-bit result and carry out
// Modports: master = client side, slave = adder side.
// ---------------------------------------------------------------------------
interface bit_serial_adder_if #(
    parameter int WIDTH = bit_serial_adder_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/bit_serial_adder_fadd.sv
// ---------------------------------------------------------------------------
// F_ADD
// One-bit full-adder cell shared by the four-bit adder family.
//   A, B, C : input bits (C is the carry in)
//   S       : sum bit
//   O       : carry out
// ---------------------------------------------------------------------------
module F_ADD (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic S,
    output logic O
);
    // Plain combinational full adder; the carry is generated when both
    // inputs are set, or propagated when exactly one is set and C is high.
    assign S = A ^ B ^ C;
    assign O = (A & B) | (C & (A ^ B));
endmodule

// File: rtl/bit_serial_adder.sv
// ---------------------------------------------------------------------------
// bit_serial_adder
// Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first,
// through a single full-adder cell with a registered carry.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of bit_serial_adder_if
//          (start, a, b, cin in; busy, done, sum, cout out)
// Result: {cout, sum} = a + b + cin. Start is accepted only in IDLE; DONE
// always falls back to IDLE, so back-to-back additions are WIDTH+2 edges apart.
// ---------------------------------------------------------------------------
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               rst,
    bit_serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_count;

    logic             w_s;
    logic             w_o;
    logic [WIDTH:0]   w_sumExt;

    // The single full-adder cell; the carry flop feeds its own O output
    // back into C on the next bit.
    F_ADD u_fadd (r_a[0], r_b[0], r_carry, w_s, w_o);

    // New sum bit enters at the MSB end while the existing bits move right;
    // slicing the extended vector keeps this legal for WIDTH = 1.
    assign w_sumExt = {w_s, r_sum};

    // Control FSM plus all datapath registers. busy/done are registered
    // alongside the state so they never depend combinationally on inputs.
    // Reset wins in every state, which also aborts an addition in flight
    // and clears any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_count <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    r_sum   <= w_sumExt[WIDTH:1];
                    r_carry <= w_o;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST_BIT) begin
                        r_cout  <= w_o;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule
